// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer and flag engine of an asynchronous FIFO.
// Everything here runs on the write clock. The read pointer arrives in Gray
// code from the read domain and passes through a two-flop synchroniser.
// All flags are computed from the post-write pointer value against that
// synchronised read pointer, so they are registered and never optimistic.
module fifo_wr_ptr_full #(
  parameter int ADDR_WIDTH  = 8,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o,
  output logic                  overflow_o
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AFULL_THRESH = (AW+1)'(AFULL_LEVEL);

  logic [AW:0] wr_bin;
  logic [AW:0] bin_next;
  logic [AW:0] gray_next;
  logic [AW:0] rq1;
  logic [AW:0] rq2;
  logic [AW:0] rd_bin_s;
  logic [AW:0] full_cmp;
  logic [AW:0] level_next;
  logic        inc;
  logic        full_next;
  logic        almost_full_next;

  // Two-flop synchroniser for the incoming read-domain Gray pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rd_ptr_gray_i;
      rq2 <= rq1;
    end
  end

  // Next pointer, its Gray form, and the flags it implies against the synced read pointer
  always_comb begin
    inc       = wr_en_i & ~full_o;
    bin_next  = wr_bin + {{AW{1'b0}}, inc};
    gray_next = (bin_next >> 1) ^ bin_next;
    full_cmp  = {~rq2[AW:AW-1], rq2[AW-2:0]};
    full_next = (gray_next == full_cmp);
    rd_bin_s  = '0;
    for (int i = 0; i <= AW; i++) begin
      rd_bin_s[i] = ^(rq2 >> i);
    end
    level_next       = bin_next - rd_bin_s;
    almost_full_next = (level_next >= AFULL_THRESH);
  end

  // Pointer and flag registers; overflow is sticky until reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_bin        <= '0;
      wr_ptr_gray_o <= '0;
      full_o        <= 1'b0;
      almost_full_o <= 1'b0;
      wr_level_o    <= '0;
      overflow_o    <= 1'b0;
    end else begin
      wr_bin        <= bin_next;
      wr_ptr_gray_o <= gray_next;
      full_o        <= full_next;
      almost_full_o <= almost_full_next;
      wr_level_o    <= level_next;
      if (wr_en_i && full_o) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // RAM strobe is suppressed while full and while reset is held
  assign mem_we_o  = wr_en_i & ~full_o & rst_n_i;
  assign wr_addr_o = wr_bin[AW-1:0];

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Self-checking bench for fifo_wr_ptr_full with a depth-4 FIFO.
// The model tracks absolute write and read counts; the read count seen by the
// write side is the one presented two clock edges earlier.
module tb_fifo_wr_ptr_full;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFULL = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW:0]   rd_gray = '0;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int rd_abs   = 0;

  int m_wr  = 0;
  int m_lvl = 0;
  int m_rd1 = 0;
  int m_rd2 = 0;
  bit m_ovf = 1'b0;

  fifo_wr_ptr_full #(.ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_en_i       (wr_en),
    .rd_ptr_gray_i (rd_gray),
    .mem_we_o      (mem_we),
    .wr_addr_o     (wr_addr),
    .wr_ptr_gray_o (wr_gray),
    .full_o        (full),
    .almost_full_o (almost_full),
    .wr_level_o    (wr_level),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the inputs for the coming clock edge, shortly after the current one
  task automatic applyStimulus(input bit we, input int rd);
    @(posedge clk);
    #2;
    wr_en   = we;
    rd_abs  = rd;
    rd_gray = to_gray(rd);
  endtask

  // Occupancy model: accept a write unless full, level = writes done minus reads visible
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr  <= 0;
      m_lvl <= 0;
      m_rd1 <= 0;
      m_rd2 <= 0;
      m_ovf <= 1'b0;
    end else begin
      automatic bit acc;
      automatic int nw;
      acc = wr_en && (m_lvl != DEPTH);
      nw  = m_wr + int'(acc);
      if (wr_en && m_lvl == DEPTH) m_ovf <= 1'b1;
      m_wr  <= nw;
      m_lvl <= nw - m_rd2;
      m_rd2 <= m_rd1;
      m_rd1 <= rd_abs;
    end
  end

  // Compare every output against the model on each falling edge
  logic [AW:0] prev_gray;
  bit          gray_valid = 1'b0;
  always @(negedge clk) begin
    checkOutput("mem_we", 32'(mem_we), 32'(rst_n && wr_en && (m_lvl != DEPTH)));
    checkOutput("wr_addr", 32'(wr_addr), 32'(m_wr % DEPTH));
    checkOutput("wr_gray", 32'(wr_gray), 32'(to_gray(m_wr)));
    checkOutput("full", 32'(full), 32'(m_lvl == DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'(m_lvl >= AFULL));
    checkOutput("wr_level", 32'(wr_level), 32'(m_lvl));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (!rst_n) begin
      gray_valid = 1'b0;
    end else begin
      if (gray_valid) checkOutput("gray_step", 32'($countones(prev_gray ^ wr_gray) <= 1), 32'd1);
      prev_gray  = wr_gray;
      gray_valid = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW:0] exp_gray [4];
    int wraps;
    int prev_addr;
    exp_gray[0] = 3'b001;
    exp_gray[1] = 3'b011;
    exp_gray[2] = 3'b010;
    exp_gray[3] = 3'b110;

    // Reset held while write requests toggle
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 wr_en = i[0];
      #1;
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_gray", 32'(wr_gray), 32'd0);
      checkOutput("rst_level", 32'(wr_level), 32'd0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    wr_en = 1'b0;
    applyStimulus(1'b0, 0);
    applyStimulus(1'b0, 0);
    #1;
    checkOutput("idle_level", 32'(wr_level), 32'd0);
    checkOutput("idle_full", 32'(full), 32'd0);

    // Four back-to-back writes fill the FIFO
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 0);
      #1;
      checkOutput("t2_addr", 32'(wr_addr), 32'(i));
      if (i > 0) checkOutput("t2_gray", 32'(wr_gray), 32'(exp_gray[i-1]));
      if (i == 1) checkOutput("t2_afull_lo", 32'(almost_full), 32'd0);
      if (i == 2) checkOutput("t2_afull_hi", 32'(almost_full), 32'd1);
    end

    // Writes while full are refused and flagged
    applyStimulus(1'b1, 0);
    #1;
    checkOutput("t3_full", 32'(full), 32'd1);
    checkOutput("t3_level", 32'(wr_level), 32'd4);
    checkOutput("t3_gray", 32'(wr_gray), 32'b110);
    checkOutput("t3_mem_we", 32'(mem_we), 32'd0);
    checkOutput("t3_ovf_lo", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 0);
    #1;
    checkOutput("t3_ovf_hi", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    #1;
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("t3_gray_hold", 32'(wr_gray), 32'b110);

    // One read becomes visible two edges after it is presented
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 1);
    #1 checkOutput("t4_full_N", 32'(full), 32'd1);
    applyStimulus(1'b0, 1);
    #1 checkOutput("t4_full_N1", 32'(full), 32'd1);
    applyStimulus(1'b1, 1);
    #1;
    checkOutput("t4_full_N2", 32'(full), 32'd0);
    checkOutput("t4_level_N2", 32'(wr_level), 32'd3);
    checkOutput("t4_mem_we", 32'(mem_we), 32'd1);
    applyStimulus(1'b0, 1);
    #1;
    checkOutput("t4_refull", 32'(full), 32'd1);
    checkOutput("t4_gray", 32'(wr_gray), 32'b111);

    // Drain to empty, then stream twelve writes with the reader keeping up
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5);
    #1 checkOutput("t5_empty", 32'(wr_level), 32'd0);
    wraps = 0;
    prev_addr = -1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 5 + k);
      #1;
      checkOutput("t5_addr", 32'(wr_addr), 32'((5 + k) % DEPTH));
      checkOutput("t5_no_full", 32'(full), 32'd0);
      if (prev_addr == 3 && wr_addr == 0) wraps++;
      prev_addr = int'(wr_addr);
    end
    applyStimulus(1'b0, 17);
    #1;
    checkOutput("t5_wraps", 32'(wraps), 32'd3);
    checkOutput("t5_gray", 32'(wr_gray), 32'(to_gray(17)));

    // Reset asserted mid-stream clears everything at once
    applyStimulus(1'b1, 17);
    applyStimulus(1'b1, 17);
    applyStimulus(1'b1, 17);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_mem_we", 32'(mem_we), 32'd0);
    checkOutput("t6_addr", 32'(wr_addr), 32'd0);
    checkOutput("t6_gray", 32'(wr_gray), 32'd0);
    checkOutput("t6_full", 32'(full), 32'd0);
    checkOutput("t6_level", 32'(wr_level), 32'd0);
    checkOutput("t6_ovf", 32'(overflow), 32'd0);
    rd_abs  = 0;
    rd_gray = '0;
    applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    checkOutput("t6_refill_addr0", 32'(wr_addr), 32'd0);
    checkOutput("t6_refill_we", 32'(mem_we), 32'd1);
    applyStimulus(1'b1, 0);
    #1;
    checkOutput("t6_refill_addr1", 32'(wr_addr), 32'd1);
    checkOutput("t6_refill_gray", 32'(wr_gray), 32'b001);
    applyStimulus(1'b0, 0);
    #1;
    checkOutput("t6_refill_level", 32'(wr_level), 32'd2);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
